// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory responder and its Wishbone master port.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } resp_state_t;

  localparam int unsigned MEM_ADDR_W      = 32;
  localparam int unsigned MEM_DATA_W      = 32;
  localparam int unsigned MEM_SEL_W       = MEM_DATA_W / 8;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/memory_responder_if.sv
// Wishbone-classic bus between the memory responder (master) and the SRAM/peripheral fabric.
interface memory_responder_if #(
  parameter int unsigned ADDR_W = mem_bus_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mem_bus_pkg::MEM_DATA_W
);

  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_W-1:0]     adr_o;
  logic [DATA_W-1:0]     dat_o;
  logic [DATA_W/8-1:0]   sel_o;
  logic [DATA_W-1:0]     dat_i;
  logic                  ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/bus_watchdog.sv
// Down-counter that flags a bus cycle left unacknowledged for CYCLES consecutive run cycles.
module bus_watchdog #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned   CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CntW-1:0] Load = CntW'(CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = Load;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= Load;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Zero is reached on the CYCLES-th run cycle after a clear.
  assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: one Wishbone-classic cycle per handler request, registered busy/data.
// Optional MEM_TIMEOUT_EN adds a bus_watchdog abort with a bus_err pulse.
module memory_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W         = MEM_ADDR_W,
  parameter int unsigned DATA_W         = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                write_to_mem,
  input  logic                read_to_mem,
  input  logic [ADDR_W-1:0]   adr_to_mem,
  input  logic [DATA_W-1:0]   data_to_mem,
  input  logic [DATA_W/8-1:0] sel_to_mem,
  output logic [DATA_W-1:0]   data_from_mem,
  output logic                mem_busy,
  output logic                data_valid,
  output logic                bus_err,
  memory_responder_if.master  wb
);

  resp_state_t state_q, state_d;

  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W/8-1:0] sel_q;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic capture;
  logic busy;
  logic expired;

  assign busy = (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
  bus_watchdog #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .nRst    (nRst),
    .clear   (capture),
    .run     (busy),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_to_mem || read_to_mem) begin
          capture = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A late ack on the expiry edge still counts as a clean completion.
        if (wb.ack_i) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = wb.dat_i;
            valid_d = 1'b1;
          end
        end else if (expired) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) begin
            rdata_d = '0;
            valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (capture) begin
        we_q  <= write_to_mem;
        adr_q <= adr_to_mem;
        dat_q <= data_to_mem;
        sel_q <= sel_to_mem;
      end
    end
  end

  // Bus strobes decode straight from the state flop so an async reset drops them at once.
  assign wb.cyc_o = busy;
  assign wb.stb_o = busy;
  assign wb.we_o  = busy & we_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.sel_o = sel_q;

  assign mem_busy      = busy;
  assign data_from_mem = rdata_q;
  assign data_valid    = valid_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed, table-driven bench for memory_responder; timeout cases build with MEM_TIMEOUT_EN.
module tb_memory_responder;

  logic        clk;
  logic        nRst;
  logic        write_to_mem;
  logic        read_to_mem;
  logic [31:0] adr_to_mem;
  logic [31:0] data_to_mem;
  logic [3:0]  sel_to_mem;
  logic [31:0] data_from_mem;
  logic        mem_busy;
  logic        data_valid;
  logic        bus_err;

  memory_responder_if #(.ADDR_W(32), .DATA_W(32)) wb ();

  memory_responder #(
    .TIMEOUT_CYCLES (4),
    .ADDR_W         (32),
    .DATA_W         (32)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .write_to_mem  (write_to_mem),
    .read_to_mem   (read_to_mem),
    .adr_to_mem    (adr_to_mem),
    .data_to_mem   (data_to_mem),
    .sel_to_mem    (sel_to_mem),
    .data_from_mem (data_from_mem),
    .mem_busy      (mem_busy),
    .data_valid    (data_valid),
    .bus_err       (bus_err),
    .wb            (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;
    logic [31:0] rdata;
    logic        exp_we;
    int          exp_busy;
    logic        exp_dv;
    logic [31:0] exp_dfm;
  } vec_t;

  localparam int NVEC = 5;
  vec_t vecs [NVEC];

  int          busy_cnt;
  logic        dv;
  logic        err;
  logic [31:0] dfm;
  logic [6:0]  pat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, ack on BUSY cycle ack_at (0 = never), return DONE-cycle observations.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                         input logic [31:0] rdata, input logic exp_we,
                         output int bcnt, output logic o_dv, output logic o_err,
                         output logic [31:0] o_dfm);
    @(negedge clk);
    write_to_mem = wr;
    read_to_mem  = rd;
    adr_to_mem   = adr;
    data_to_mem  = dat;
    sel_to_mem   = sel;
    @(negedge clk);
    write_to_mem = 1'b0;
    read_to_mem  = 1'b0;
    bcnt = 0;
    while (mem_busy && bcnt < 40) begin
      bcnt++;
      if (bcnt == 1) begin
        check("busy_cyc_o", 64'(wb.cyc_o), 64'(1));
        check("busy_stb_o", 64'(wb.stb_o), 64'(1));
        check("busy_we_o", 64'(wb.we_o), 64'(exp_we));
        check("busy_adr_o", 64'(wb.adr_o), 64'(adr));
        check("busy_dat_o", 64'(wb.dat_o), 64'(dat));
        check("busy_sel_o", 64'(wb.sel_o), 64'(sel));
      end
      wb.ack_i = (bcnt == ack_at);
      wb.dat_i = rdata;
      @(negedge clk);
      wb.ack_i = 1'b0;
    end
    if (mem_busy) check("busy_wait_bound", 64'(mem_busy), 64'(0));
    o_dv  = data_valid;
    o_err = bus_err;
    o_dfm = data_from_mem;
    check("done_cyc_o", 64'(wb.cyc_o), 64'(0));
    check("done_we_o", 64'(wb.we_o), 64'(0));
    @(negedge clk);
    check("idle_data_valid", 64'(data_valid), 64'(0));
    check("idle_bus_err", 64'(bus_err), 64'(0));
    check("idle_mem_busy", 64'(mem_busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc_o"}, 64'(wb.cyc_o), 64'(0));
    check({tag, "_stb_o"}, 64'(wb.stb_o), 64'(0));
    check({tag, "_we_o"}, 64'(wb.we_o), 64'(0));
    check({tag, "_adr_o"}, 64'(wb.adr_o), 64'(0));
    check({tag, "_dat_o"}, 64'(wb.dat_o), 64'(0));
    check({tag, "_sel_o"}, 64'(wb.sel_o), 64'(0));
    check({tag, "_mem_busy"}, 64'(mem_busy), 64'(0));
    check({tag, "_data_valid"}, 64'(data_valid), 64'(0));
    check({tag, "_bus_err"}, 64'(bus_err), 64'(0));
    check({tag, "_data_from_mem"}, 64'(data_from_mem), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // wr rd adr dat sel ack_at rdata | exp_we exp_busy exp_dv exp_dfm
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, 2, 32'hDEAD_BEEF,
                1'b0, 2, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 4'b0011, 1, 32'hAAAA_5555,
                1'b1, 1, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 3, 32'h1357_9BDF,
                1'b1, 3, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0000_0001, 4'h0, 1, 32'h0BAD_F00D,
                1'b0, 1, 1'b1, 32'h0BAD_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0002, 4'hF, 3, 32'h0123_4567,
                1'b0, 3, 1'b1, 32'h0123_4567};

    nRst         = 1'b0;
    write_to_mem = 1'b0;
    read_to_mem  = 1'b0;
    adr_to_mem   = '0;
    data_to_mem  = '0;
    sel_to_mem   = '0;
    wb.ack_i     = 1'b0;
    wb.dat_i     = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    nRst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i].wr, vecs[i].rd, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].ack_at,
              vecs[i].rdata, vecs[i].exp_we, busy_cnt, dv, err, dfm);
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt), 64'(vecs[i].exp_busy));
      check($sformatf("v%0d_data_valid", i), 64'(dv), 64'(vecs[i].exp_dv));
      check($sformatf("v%0d_data_from_mem", i), 64'(dfm), 64'(vecs[i].exp_dfm));
      check($sformatf("v%0d_bus_err", i), 64'(err), 64'(0));
    end

    // Request held through DONE: BUSY, DONE, IDLE, BUSY, ... with ack on each BUSY cycle.
    @(negedge clk);
    read_to_mem = 1'b1;
    adr_to_mem  = 32'h0000_0080;
    wb.dat_i    = 32'h5555_AAAA;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      wb.ack_i = 1'b0;
      pat[c]   = wb.cyc_o;
      wb.ack_i = wb.cyc_o;
      if (c == 6) read_to_mem = 1'b0;
    end
    @(negedge clk);
    wb.ack_i = 1'b0;
    check("held_cyc_pattern", 64'(pat), 64'(7'b1001001));
    check("held_data_from_mem", 64'(data_from_mem), 64'(32'h5555_AAAA));
    @(negedge clk);
    check("held_released_busy", 64'(mem_busy), 64'(0));

    // Handler inputs changing mid-BUSY must not disturb the captured cycle.
    @(negedge clk);
    read_to_mem = 1'b1;
    adr_to_mem  = 32'h0000_0100;
    sel_to_mem  = 4'hF;
    @(negedge clk);
    read_to_mem  = 1'b0;
    write_to_mem = 1'b1;
    adr_to_mem   = 32'h0000_0200;
    sel_to_mem   = 4'h0;
    @(negedge clk);
    check("ignore_adr_o", 64'(wb.adr_o), 64'(32'h0000_0100));
    check("ignore_we_o", 64'(wb.we_o), 64'(0));
    check("ignore_sel_o", 64'(wb.sel_o), 64'(4'hF));
    wb.ack_i = 1'b1;
    wb.dat_i = 32'h0000_0077;
    @(negedge clk);
    wb.ack_i     = 1'b0;
    write_to_mem = 1'b0;
    check("ignore_data_valid", 64'(data_valid), 64'(1));
    check("ignore_data_from_mem", 64'(data_from_mem), 64'(32'h0000_0077));
    @(negedge clk);
    check("ignore_idle_busy", 64'(mem_busy), 64'(0));

    // Stray ack while idle is ignored.
    wb.ack_i = 1'b1;
    wb.dat_i = 32'hFFFF_0000;
    @(negedge clk);
    wb.ack_i = 1'b0;
    check("idle_ack_data_valid", 64'(data_valid), 64'(0));
    check("idle_ack_data_from_mem", 64'(data_from_mem), 64'(32'h0000_0077));
    check("idle_ack_mem_busy", 64'(mem_busy), 64'(0));

`ifdef MEM_TIMEOUT_EN
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'hF, 0, 32'h1111_1111, 1'b0,
            busy_cnt, dv, err, dfm);
    check("timeout_busy_cycles", 64'(busy_cnt), 64'(4));
    check("timeout_bus_err", 64'(err), 64'(1));
    check("timeout_data_valid", 64'(dv), 64'(1));
    check("timeout_data_from_mem", 64'(dfm), 64'(0));
    run_txn(1'b0, 1'b1, 32'h0000_0404, 32'h0, 4'hF, 4, 32'h2222_2222, 1'b0,
            busy_cnt, dv, err, dfm);
    check("late_ack_busy_cycles", 64'(busy_cnt), 64'(4));
    check("late_ack_bus_err", 64'(err), 64'(0));
    check("late_ack_data_valid", 64'(dv), 64'(1));
    check("late_ack_data_from_mem", 64'(dfm), 64'(32'h2222_2222));
`else
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'hF, 20, 32'h3333_3333, 1'b0,
            busy_cnt, dv, err, dfm);
    check("long_wait_busy_cycles", 64'(busy_cnt), 64'(20));
    check("long_wait_bus_err", 64'(err), 64'(0));
    check("long_wait_data_from_mem", 64'(dfm), 64'(32'h3333_3333));
`endif

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    write_to_mem = 1'b1;
    adr_to_mem   = 32'h0000_0300;
    data_to_mem  = 32'h0000_0009;
    sel_to_mem   = 4'hF;
    @(negedge clk);
    write_to_mem = 1'b0;
    check("pre_reset_busy", 64'(mem_busy), 64'(1));
    #2 nRst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 64'(mem_busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
